tdm_sym_fir: RTL

Time-multiplexed, parametrised systolic symmetric FIR: one filter datapath serves CH interleaved channels, with valid-qualified, stall-tolerant streaming and run-time coefficient reload through a shadow bank. Successor to the single-channel fixed-coefficient systolic FIR. Sits between the ADC/decimator front end and downstream channel processing.

---
 rtl/tdm_sym_fir_pkg.sv | 28 ++
 rtl/tdm_preadder_mac.sv | 47 ++++
 rtl/tdm_sym_fir.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/tdm_sym_fir_pkg.sv
// Shared defaults, reset coefficient set, swap FSM encoding and latency helper
// for the time-multiplexed symmetric FIR.
package tdm_sym_fir_pkg;
  localparam int DEF_XIN_W  = 16;
  localparam int DEF_COE_W  = 18;
  localparam int DEF_TAP    = 16;
  localparam int DEF_CH     = 4;
  localparam int DEF_ACC_W  = 48;
  localparam int DEF_YOUT_W = 24;
  localparam int DEF_HTAP   = DEF_TAP / 2;

  typedef logic signed [DEF_COE_W-1:0] coef_arr_t [DEF_HTAP];

  // Smaller filters take the leading entries of this set.
  localparam coef_arr_t COE_INIT = '{18'sd1, 18'sd2, 18'sd3, 18'sd4,
                                     18'sd5, 18'sd6, 18'sd7, 18'sd8};

  typedef enum logic {SW_IDLE, SW_PEND} swap_st_e;

  function automatic int fir_lat(input int ch, input int htap);
    return ch * (htap + 1);
  endfunction

  function automatic logic signed [DEF_COE_W-1:0] coe_init(input int i);
    coe_init = '0;
    if (i < DEF_HTAP) coe_init = COE_INIT[i[$clog2(DEF_HTAP)-1:0]];
  endfunction
endpackage

// File: rtl/tdm_preadder_mac.sv
// One systolic tap: pre-add two samples, scale by a coefficient, add the
// upstream partial sum, and hold results in a CH-deep shift register.
module tdm_preadder_mac #(
  parameter int XIN_W = 16,
  parameter int COE_W = 18,
  parameter int ACC_W = 48,
  parameter int CH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [XIN_W-1:0] a,
  input  logic [XIN_W-1:0] b,
  input  logic [COE_W-1:0] coe,
  input  logic [ACC_W-1:0] acc_in,
  output logic [ACC_W-1:0] acc_out
);
  localparam int PW = XIN_W + COE_W + 1;

  logic signed [XIN_W:0]   pre;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] mac;
  logic [ACC_W-1:0] sr_q [CH];
  logic [ACC_W-1:0] sr_d [CH];

  always_comb begin
    pre  = (XIN_W+1)'($signed(a)) + (XIN_W+1)'($signed(b));
    prod = PW'(pre) * PW'($signed(coe));
    mac  = $signed(acc_in) + ACC_W'(prod);
    sr_d = sr_q;
    if (ce) begin
      sr_d[0] = mac;
      for (int k = 1; k < CH; k++) sr_d[k] = sr_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CH; k++) sr_q[k] <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Tail holds this channel's partial sum from one channel-sample ago.
  assign acc_out = sr_q[CH-1];
endmodule

// File: rtl/tdm_sym_fir.sv
// CH-channel interleaved symmetric FIR with shadow coefficient bank.
// Define SYM_FIR_SAT_EN to clamp outputs instead of wrapping.
module tdm_sym_fir
  import tdm_sym_fir_pkg::*;
#(
  parameter int XIN_W      = DEF_XIN_W,
  parameter int COE_W      = DEF_COE_W,
  parameter int TAP        = DEF_TAP,
  parameter int CH         = DEF_CH,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int YOUT_W     = DEF_YOUT_W,
  parameter int YOUT_SHIFT = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                s_valid,
  input  logic [XIN_W-1:0]                    s_data,
  output logic                                m_valid,
  output logic [YOUT_W-1:0]                   m_data,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] m_ch,
  input  logic                                coef_wr,
  input  logic [$clog2(TAP/2)-1:0]            coef_addr,
  input  logic [COE_W-1:0]                    coef_data,
  input  logic                                coef_swap,
  output logic                                swap_pend
);
  localparam int HTAP = TAP / 2;
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int LAT  = fir_lat(CH, HTAP);
  localparam int FW   = $clog2(LAT + 1);
  localparam int DL   = CH * (TAP - 1);
  localparam logic signed [ACC_W-1:0] YMAX = {{(ACC_W-YOUT_W+1){1'b0}}, {(YOUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] YMIN = ~YMAX;

  logic [XIN_W-1:0] xd_q [DL];
  logic [XIN_W-1:0] xd_d [DL];
  logic [ACC_W-1:0] pad_q [CH];
  logic [ACC_W-1:0] pad_d [CH];
  logic [COE_W-1:0] shad_q [HTAP];
  logic [COE_W-1:0] shad_d [HTAP];
  logic [COE_W-1:0] act_q [HTAP];
  logic [COE_W-1:0] act_d [HTAP];
  logic [CHW-1:0]    ch_in_q, ch_in_d, m_ch_q, m_ch_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [YOUT_W-1:0] m_data_q, m_data_d, y_red;
  logic              m_valid_q, m_valid_d, swap_pend_q, swap_fire;
  logic signed [ACC_W-1:0] acc_sh;
  logic [HTAP-1:0][ACC_W-1:0] acc_t;
  swap_st_e st_q;

  assign swap_fire = (st_q == SW_PEND) && s_valid && (ch_in_q == '0);

  // Tap i pairs x[m-2i] with x[m-(TAP-1)] so each partial sum stays aligned
  // as it walks down the chain one channel-sample per stage.
  for (genvar i = 0; i < HTAP; i++) begin : g_tap
    logic [ACC_W-1:0] acc_in;
    logic [XIN_W-1:0] a_s;
    if (i == 0) begin : g_first
      assign acc_in = '0;
      assign a_s    = s_data;
    end else begin : g_next
      assign acc_in = acc_t[i-1];
      assign a_s    = xd_q[2*i*CH-1];
    end
    tdm_preadder_mac #(.XIN_W(XIN_W), .COE_W(COE_W), .ACC_W(ACC_W), .CH(CH)) u_mac (
      .clk(clk), .rst_n(rst_n), .ce(s_valid), .a(a_s), .b(xd_q[DL-1]),
      .coe(act_q[i]), .acc_in(acc_in), .acc_out(acc_t[i])
    );
  end

  always_comb begin
    xd_d   = xd_q;
    pad_d  = pad_q;
    shad_d = shad_q;
    act_d  = act_q;
    if (s_valid) begin
      xd_d[0]  = s_data;
      for (int k = 1; k < DL; k++) xd_d[k] = xd_q[k-1];
      pad_d[0] = acc_t[HTAP-1];
      for (int k = 1; k < CH; k++) pad_d[k] = pad_q[k-1];
    end
    // Copy reads the registered shadow, so a same-cycle write lands later.
    if (swap_fire) act_d = shad_q;
    if (coef_wr && (int'(coef_addr) < HTAP)) shad_d[coef_addr] = coef_data;

    ch_in_d = ch_in_q;
    if (s_valid) ch_in_d = (ch_in_q == CHW'(CH-1)) ? '0 : ch_in_q + 1'b1;
    fill_d = fill_q;
    if (s_valid && (fill_q != FW'(LAT))) fill_d = fill_q + 1'b1;

    acc_sh = $signed(pad_q[CH-1]) >>> YOUT_SHIFT;
`ifdef SYM_FIR_SAT_EN
    if (acc_sh > YMAX)      y_red = YOUT_W'(YMAX);
    else if (acc_sh < YMIN) y_red = YOUT_W'(YMIN);
    else                    y_red = YOUT_W'(acc_sh);
`else
    y_red = YOUT_W'(acc_sh);
`endif
    m_valid_d = s_valid && (fill_q == FW'(LAT));
    m_data_d  = s_valid ? y_red : m_data_q;
    // LAT is a multiple of CH, so the presented channel equals ch_in.
    m_ch_d    = s_valid ? ch_in_q : m_ch_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DL; k++) xd_q[k] <= '0;
      for (int k = 0; k < CH; k++) pad_q[k] <= '0;
      for (int i = 0; i < HTAP; i++) begin
        shad_q[i] <= COE_W'(coe_init(i));
        act_q[i]  <= COE_W'(coe_init(i));
      end
      ch_in_q   <= '0;
      fill_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ch_q    <= '0;
    end else begin
      xd_q      <= xd_d;
      pad_q     <= pad_d;
      shad_q    <= shad_d;
      act_q     <= act_d;
      ch_in_q   <= ch_in_d;
      fill_q    <= fill_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ch_q    <= m_ch_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= SW_IDLE;
      swap_pend_q <= 1'b0;
    end else begin
      case (st_q)
        SW_IDLE: if (coef_swap) begin
          st_q        <= SW_PEND;
          swap_pend_q <= 1'b1;
        end
        SW_PEND: if (swap_fire) begin
          st_q        <= SW_IDLE;
          swap_pend_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_ch      = m_ch_q;
  assign swap_pend = swap_pend_q;
endmodule
